// File: rtl/sprite_pkg.sv
// ----------------------------------------------------------------------------
// sprite_pkg
// Shared constants and types for the sprite position controller.
//   - Screen and sprite dimensions, and the largest legal top-left
//     coordinate on each axis (XMAX/YMAX).
//   - Output and arithmetic widths.
//   - Speed state encoding (IDLE, SLOW, FAST).
//   - Edge-handling helpers: clamp to [0, max] or wrap around the
//     (max+1)-wide axis. The top picks one with SPRITE_POS_CTRL_WRAP_EN.
// ----------------------------------------------------------------------------
package sprite_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 14;
    localparam int SPRITE_H = 14;

    // Largest top-left coordinate that keeps the whole sprite visible.
    localparam int XMAX = SCREEN_W - SPRITE_W;   // 626
    localparam int YMAX = SCREEN_H - SPRITE_H;   // 466

    localparam int X_W    = 10;  // sprite_x width
    localparam int Y_W    = 9;   // sprite_y width
    localparam int CALC_W = 12;  // signed working width for position maths

    typedef enum logic [1:0] {
        SPD_IDLE = 2'd0,
        SPD_SLOW = 2'd1,
        SPD_FAST = 2'd2
    } speed_state_t;

    // Saturate a candidate coordinate into [0, max_v]. A step that would
    // overshoot lands exactly on the boundary.
    function automatic int clamp_axis(input logic signed [CALC_W-1:0] v,
                                      input int max_v);
        int vi;
        int r;
        vi = int'(v);
        if (vi < 0)
            r = 0;
        else if (vi > max_v)
            r = max_v;
        else
            r = vi;
        return r;
    endfunction

    // Wrap a candidate coordinate around an axis of max_v+1 positions.
    // A step is at most a few pixels, so one correction is enough.
    function automatic int wrap_axis(input logic signed [CALC_W-1:0] v,
                                     input int max_v);
        int vi;
        int r;
        vi = int'(v);
        if (vi > max_v)
            r = vi - (max_v + 1);
        else if (vi < 0)
            r = vi + (max_v + 1);
        else
            r = vi;
        return r;
    endfunction

endpackage

// File: rtl/sprite_pos_ctrl_btn_sync.sv
// ----------------------------------------------------------------------------
// btn_sync
// Parameterised-width two-flop synchroniser for asynchronous button inputs.
// Each bit is synchronised independently; no debouncing is applied.
//
// Ports:
//   i_clk    in   1      destination clock
//   i_rst_n  in   1      asynchronous active-low reset, clears both stages
//   i_async  in   WIDTH  asynchronous inputs
//   o_sync   out  WIDTH  synchronised outputs (two-cycle latency)
// ----------------------------------------------------------------------------
module btn_sync #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from the same clock edge and form a true shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/sprite_pos_ctrl.sv
// ----------------------------------------------------------------------------
// sprite_pos_ctrl
// Generates the blue square sprite's top-left pixel position from gamepad
// buttons. Buttons are synchronised, then sampled only on frame_tick (start
// of vertical blank) so the position never changes mid-scan. Holding any
// direction moves STEP pixels per frame; after HOLD_FRAMES held frames the
// speed FSM switches to FAST and moves FAST_STEP pixels per frame.
// btn_center recentres the sprite and drops back to IDLE.
//
// Build option:
//   SPRITE_POS_CTRL_WRAP_EN  defined   -> the sprite wraps at screen edges
//                            undefined -> the sprite is clamped at edges
//
// Ports:
//   CLK         in   1   system clock
//   RST_N       in   1   asynchronous active-low reset
//   btn_up      in   1   asynchronous button, 1 = pressed
//   btn_down    in   1   asynchronous button, 1 = pressed
//   btn_left    in   1   asynchronous button, 1 = pressed
//   btn_right   in   1   asynchronous button, 1 = pressed
//   btn_center  in   1   asynchronous button, 1 = pressed (recentre)
//   frame_tick  in   1   one-cycle pulse at start of vertical blank
//   sprite_x    out  10  sprite top-left x
//   sprite_y    out  9   sprite top-left y
//   moved       out  1   one-cycle pulse when the position changed
//   fast        out  1   speed FSM is in FAST
// ----------------------------------------------------------------------------
module sprite_pos_ctrl
    import sprite_pkg::*;
#(
    parameter int START_X     = 313,
    parameter int START_Y     = 233,
    parameter int STEP        = 1,
    parameter int FAST_STEP   = 4,
    parameter int HOLD_FRAMES = 30
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           btn_up,
    input  logic           btn_down,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_center,
    input  logic           frame_tick,
    output logic [X_W-1:0] sprite_x,
    output logic [Y_W-1:0] sprite_y,
    output logic           moved,
    output logic           fast
);

    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

    // ------------------------------------------------------------------
    // Button synchronisation: {center, up, down, left, right}
    // ------------------------------------------------------------------
    logic [4:0] w_btn_raw;
    logic [4:0] w_btn_s;

    assign w_btn_raw = {btn_center, btn_up, btn_down, btn_left, btn_right};

    btn_sync #(
        .WIDTH (5)
    ) u_btn_sync (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_async (w_btn_raw),
        .o_sync  (w_btn_s)
    );

    logic w_center;
    logic w_up;
    logic w_down;
    logic w_left;
    logic w_right;

    assign w_center = w_btn_s[4];
    assign w_up     = w_btn_s[3];
    assign w_down   = w_btn_s[2];
    assign w_left   = w_btn_s[1];
    assign w_right  = w_btn_s[0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             r_moved;
    logic             r_fast;
    speed_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;

    // ------------------------------------------------------------------
    // Candidate next position. Opposite buttons cancel on an axis, so an
    // axis is active exactly when one (and only one) of its pair is held.
    // The step size comes from the speed state before this tick.
    // ------------------------------------------------------------------
    logic                     w_held;
    logic signed [CALC_W-1:0] w_step;
    logic signed [CALC_W-1:0] w_dx_delta;
    logic signed [CALC_W-1:0] w_dy_delta;
    logic signed [CALC_W-1:0] w_x_sum;
    logic signed [CALC_W-1:0] w_y_sum;
    logic [X_W-1:0]           w_x_next;
    logic [Y_W-1:0]           w_y_next;
    logic                     w_pos_changes;

    assign w_held = (w_right ^ w_left) | (w_down ^ w_up);
    assign w_step = (r_state == SPD_FAST) ? CALC_W'(FAST_STEP) : CALC_W'(STEP);

    // NOTE: every signal driven here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_dx_delta = '0;
        w_dy_delta = '0;
        if (w_right && !w_left)
            w_dx_delta = w_step;
        else if (w_left && !w_right)
            w_dx_delta = -w_step;
        if (w_down && !w_up)
            w_dy_delta = w_step;
        else if (w_up && !w_down)
            w_dy_delta = -w_step;
    end

    // Zero-extend the unsigned position into the signed working width.
    assign w_x_sum = $signed({{(CALC_W - X_W){1'b0}}, r_x}) + w_dx_delta;
    assign w_y_sum = $signed({{(CALC_W - Y_W){1'b0}}, r_y}) + w_dy_delta;

`ifdef SPRITE_POS_CTRL_WRAP_EN
    assign w_x_next = X_W'(wrap_axis(w_x_sum, XMAX));
    assign w_y_next = Y_W'(wrap_axis(w_y_sum, YMAX));
`else
    assign w_x_next = X_W'(clamp_axis(w_x_sum, XMAX));
    assign w_y_next = Y_W'(clamp_axis(w_y_sum, YMAX));
`endif

    // A clamped step that leaves the sprite in place is not a move.
    assign w_pos_changes = (w_x_next != r_x) || (w_y_next != r_y);

    // ------------------------------------------------------------------
    // Position registers and speed FSM. Everything advances only on
    // frame_tick; moved is cleared on every other cycle so it pulses once.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_x     <= X_W'(START_X);
            r_y     <= Y_W'(START_Y);
            r_moved <= 1'b0;
            r_fast  <= 1'b0;
            r_state <= SPD_IDLE;
            r_cnt   <= '0;
        end else if (frame_tick) begin
            if (w_center) begin
                // Recentre overrides any direction held on the same tick.
                r_x     <= X_W'(START_X);
                r_y     <= Y_W'(START_Y);
                r_moved <= (r_x != X_W'(START_X)) || (r_y != Y_W'(START_Y));
                r_fast  <= 1'b0;
                r_state <= SPD_IDLE;
                r_cnt   <= '0;
            end else begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_moved <= w_pos_changes;

                unique case (r_state)
                    SPD_IDLE: begin
                        if (w_held) begin
                            r_state <= SPD_SLOW;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    SPD_SLOW: begin
                        if (w_held) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            // This tick brings the count to HOLD_FRAMES.
                            if (r_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
                                r_state <= SPD_FAST;
                                r_fast  <= 1'b1;
                            end
                        end else begin
                            r_state <= SPD_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    SPD_FAST: begin
                        // Counter holds at HOLD_FRAMES while in FAST.
                        if (!w_held) begin
                            r_state <= SPD_IDLE;
                            r_fast  <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= SPD_IDLE;
                        r_fast  <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end else begin
            r_moved <= 1'b0;
        end
    end

    assign sprite_x = r_x;
    assign sprite_y = r_y;
    assign moved    = r_moved;
    assign fast     = r_fast;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sprite_pos_ctrl
// Self-checking bench for sprite_pos_ctrl. A frame-level model tracks the
// position and the number of consecutive held frames; a compare process
// checks every output on every falling clock edge against it, and directed
// scenarios pin the model with hand-computed literal values.
// Buttons are always held stable for several cycles before a frame_tick so
// the synchroniser latency does not matter to the model.
// ----------------------------------------------------------------------------
module tb_sprite_pos_ctrl;

    localparam int XMAX_TB = 626;
    localparam int YMAX_TB = 466;
    localparam int SX      = 313;
    localparam int SY      = 233;
    localparam int HOLD    = 30;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_center;
    logic       frame_tick;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic       moved;
    logic       fast;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    sprite_pos_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_center (btn_center),
        .frame_tick (frame_tick),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .moved      (moved),
        .fast       (fast)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Frame-level model
    // ------------------------------------------------------------------
    int m_x;
    int m_y;
    int m_held;   // consecutive held frames, saturating at HOLD
    bit m_moved;

    function automatic int move_axis(input int p, input int d, input int s, input int mx);
        int n;
        n = p + d * s;
`ifdef SPRITE_POS_CTRL_WRAP_EN
        if (n > mx) n = n - (mx + 1);
        else if (n < 0) n = n + (mx + 1);
`else
        if (n > mx) n = mx;
        else if (n < 0) n = 0;
`endif
        return n;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        int dx;
        int dy;
        int s;
        int nx;
        int ny;
        if (!RST_N) begin
            m_x     <= SX;
            m_y     <= SY;
            m_held  <= 0;
            m_moved <= 1'b0;
        end else if (frame_tick) begin
            if (btn_center) begin
                m_x     <= SX;
                m_y     <= SY;
                m_held  <= 0;
                m_moved <= (m_x != SX) || (m_y != SY);
            end else begin
                dx = int'(btn_right) - int'(btn_left);
                dy = int'(btn_down) - int'(btn_up);
                s  = (m_held >= HOLD) ? 4 : 1;
                nx = move_axis(m_x, dx, s, XMAX_TB);
                ny = move_axis(m_y, dy, s, YMAX_TB);
                m_moved <= (nx != m_x) || (ny != m_y);
                m_x     <= nx;
                m_y     <= ny;
                if (dx != 0 || dy != 0)
                    m_held <= (m_held >= HOLD) ? HOLD : m_held + 1;
                else
                    m_held <= 0;
            end
        end else begin
            m_moved <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model_x", int'(sprite_x), m_x);
            check("model_y", int'(sprite_y), m_y);
            check("model_moved", int'(moved), int'(m_moved));
            check("model_fast", int'(fast), (m_held >= HOLD) ? 1 : 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_btn(input bit c, input bit u, input bit d, input bit l, input bit r);
        btn_center = c;
        btn_up     = u;
        btn_down   = d;
        btn_left   = l;
        btn_right  = r;
    endtask

    // Let the buttons settle through the synchroniser, pulse frame_tick
    // for one cycle, and return on the falling edge where the result shows.
    task automatic tick();
        repeat (4) @(negedge CLK);
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tap(input bit u, input bit d, input bit l, input bit r);
        set_btn(0, u, d, l, r);
        tick();
        set_btn(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        RST_N      = 1'b0;
        frame_tick = 1'b0;
        set_btn(0, 0, 0, 0, 0);
        repeat (3) @(negedge CLK);
        cmp_en = 1'b1;
        RST_N  = 1'b1;
        @(negedge CLK);

        // Reset values
        check("rst_x", int'(sprite_x), 313);
        check("rst_y", int'(sprite_y), 233);
        check("rst_moved", int'(moved), 0);
        check("rst_fast", int'(fast), 0);

        // Buttons without frame_tick never move the sprite
        for (int i = 0; i < 8; i++) begin
            set_btn(0, i[0], i[1], i[2], ~i[0]);
            repeat (3) @(negedge CLK);
        end
        check("notick_x", int'(sprite_x), 313);
        check("notick_y", int'(sprite_y), 233);
        set_btn(0, 0, 0, 0, 0);

        // Recentre at the start position is not a move
        set_btn(1, 0, 0, 0, 0);
        tick();
        check("center_at_start_moved", int'(moved), 0);
        set_btn(0, 0, 0, 0, 0);

        // Hold right: slow for 30 ticks, fast from tick 31
        set_btn(0, 0, 0, 0, 1);
        for (int t = 1; t <= 31; t++) begin
            tick();
            if (t == 1) begin
                check("hold1_x", int'(sprite_x), 314);
                check("hold1_moved", int'(moved), 1);
                check("hold1_fast", int'(fast), 0);
            end
            if (t == 29) check("hold29_fast", int'(fast), 0);
            if (t == 30) begin
                check("hold30_x", int'(sprite_x), 343);
                check("hold30_fast", int'(fast), 1);
            end
            if (t == 31) check("hold31_x", int'(sprite_x), 347);
        end
        @(negedge CLK);
        check("moved_pulse_len", int'(moved), 0);
        ticks(69);
        check("hold100_x", int'(sprite_x), 623);

        // Step to x=624, then build FAST on the y axis only
        set_btn(0, 0, 0, 0, 0);
        tick();
        check("release_fast", int'(fast), 0);
        tap(0, 0, 0, 1);
        check("x624", int'(sprite_x), 624);
        set_btn(0, 0, 1, 0, 0);
        ticks(30);
        check("down30_y", int'(sprite_y), 263);
        check("down30_fast", int'(fast), 1);

        // Right edge in FAST
        set_btn(0, 0, 0, 0, 1);
        tick();
`ifdef SPRITE_POS_CTRL_WRAP_EN
        check("edge_r_x", int'(sprite_x), 1);
        check("edge_r_moved", int'(moved), 1);
        tick();
        check("edge_r2_x", int'(sprite_x), 5);
`else
        check("edge_r_x", int'(sprite_x), 626);
        check("edge_r_moved", int'(moved), 1);
        tick();
        check("edge_r2_x", int'(sprite_x), 626);
        check("edge_r2_moved", int'(moved), 0);
`endif

        // Left edge in FAST
        set_btn(0, 0, 0, 1, 0);
        for (int t = 1; t <= 158; t++) begin
            tick();
`ifndef SPRITE_POS_CTRL_WRAP_EN
            if (t == 156) check("edge_l156_x", int'(sprite_x), 2);
            if (t == 157) begin
                check("edge_l157_x", int'(sprite_x), 0);
                check("edge_l157_moved", int'(moved), 1);
            end
            if (t == 158) begin
                check("edge_l158_x", int'(sprite_x), 0);
                check("edge_l158_moved", int'(moved), 0);
            end
`endif
        end

        // Reset mid-hold takes effect at once; frame_tick ignored in reset
        set_btn(0, 0, 0, 0, 1);
        ticks(3);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_x", int'(sprite_x), 313);
        check("midrst_y", int'(sprite_y), 233);
        check("midrst_moved", int'(moved), 0);
        check("midrst_fast", int'(fast), 0);
        @(negedge CLK);
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
        check("rst_tick_ignored_x", int'(sprite_x), 313);
        RST_N = 1'b1;
        tick();
        check("after_rst_x", int'(sprite_x), 314);
        check("after_rst_fast", int'(fast), 0);
        set_btn(0, 0, 0, 0, 0);
        tick();

        // Reach x=2 in FAST, then one more left step
        for (int i = 0; i < 4; i++) tap(0, 0, 1, 0);
        check("probe_x310", int'(sprite_x), 310);
        set_btn(0, 0, 1, 0, 0);
        ticks(30);
        set_btn(0, 0, 0, 1, 0);
        ticks(77);
        check("probe_x2", int'(sprite_x), 2);
        check("probe_fast", int'(fast), 1);
        tick();
`ifdef SPRITE_POS_CTRL_WRAP_EN
        check("probe_wrap_x", int'(sprite_x), 625);
`else
        check("probe_clamp_x", int'(sprite_x), 0);
`endif
        set_btn(0, 0, 0, 0, 0);
        tick();

        // Travel to (400,100) ending in FAST, then recentre with right held
        do_reset();
        set_btn(0, 0, 0, 0, 1);
        ticks(44);
        set_btn(0, 0, 0, 0, 0);
        tick();
        tap(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) tap(1, 0, 0, 0);
        set_btn(0, 1, 0, 0, 0);
        ticks(55);
        check("at_400_x", int'(sprite_x), 400);
        check("at_400_y", int'(sprite_y), 100);
        check("at_400_fast", int'(fast), 1);
        set_btn(1, 0, 0, 0, 1);
        tick();
        check("center_x", int'(sprite_x), 313);
        check("center_y", int'(sprite_y), 233);
        check("center_moved", int'(moved), 1);
        check("center_fast", int'(fast), 0);

        // Opposite x buttons cancel, up still applies, at slow speed
        set_btn(0, 1, 0, 1, 1);
        tick();
        check("lru_x", int'(sprite_x), 313);
        check("lru_y", int'(sprite_y), 232);
        check("lru_moved", int'(moved), 1);

        set_btn(0, 0, 0, 0, 0);
        repeat (6) @(negedge CLK);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
